// File: rtl/mem_io_pkg.sv
// Address map, decode helpers and request payload shared by the memory/IO responder.
package mem_io_pkg;

    localparam int unsigned DEC_W     = 18;
    localparam int unsigned IO_SEL_HI = 17;
    localparam int unsigned IO_SEL_LO = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CYC_W     = 32;

    localparam logic [1:0]       IO_SEL_VAL   = 2'b11;
    localparam logic [DEC_W-1:0] IO_UART_ADDR = 18'h30000;
    localparam logic [DEC_W-1:0] IO_STOP_ADDR = 18'h30004;

    typedef enum logic [1:0] {
        IO_OTHER,
        IO_UART,
        IO_CNT
    } io_reg_e;

    typedef struct packed {
        logic [DEC_W-1:0]  addr;
        logic              wr;
        logic [BYTE_W-1:0] data;
    } mem_req_t;

    // 0x30004..0x30007 share the counter window; 0x30004 doubles as the stop register.
    function automatic io_reg_e decode_io(input logic [DEC_W-1:0] addr);
        io_reg_e sel;
        sel = IO_OTHER;
        if (addr == IO_UART_ADDR) begin
            sel = IO_UART;
        end else if (addr[DEC_W-1:2] == IO_STOP_ADDR[DEC_W-1:2]) begin
            sel = IO_CNT;
        end
        return sel;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module byte_fifo
    import mem_io_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [BYTE_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = store[rd_ptr];

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM below 0x30000, UART FIFOs, stop flag and cycle counter in IO space.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int unsigned TX_CNT_W  = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CNT_W  = $clog2(RX_DEPTH) + 1;
    localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;

    mem_req_t              req;
    io_reg_e               io_reg;
    logic                  io_hit;
    logic                  stop_hit;
    logic [1:0]            cnt_byte;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [BYTE_W-1:0]     rd_next;
    logic [CYC_W-1:0]      cycle_cnt;

    logic                  tx_push;
    logic [BYTE_W-1:0]     tx_push_data;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic [TX_CNT_W-1:0]   tx_count;

    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_full;
    logic                  rx_empty;
    logic [BYTE_W-1:0]     rx_head;
    logic [RX_CNT_W-1:0]   rx_count;

    logic                  unused_hi;
    logic                  unused_rx_count;

    assign req = '{addr: mem_a[DEC_W-1:0], wr: mem_wr, data: mem_dout};
    assign unused_hi       = ^mem_a[31:DEC_W];
    assign unused_rx_count = ^rx_count;

    assign io_hit   = (req.addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
    assign io_reg   = decode_io(req.addr);
    assign stop_hit = req.wr && (req.addr == IO_STOP_ADDR);
    assign cnt_byte = req.addr[1:0];
    assign ram_idx  = mem_a[ADDR_WIDTH-1:0];

    // RAM: write lands on the presenting edge, so a following read sees it.
    logic [BYTE_W-1:0] ram [RAM_BYTES];

    always_ff @(posedge clk_in) begin
        if (req.wr && !io_hit) begin
            ram[ram_idx] <= req.data;
        end
    end

    // A zero byte to the UART register is a no-op; the stop register emits a 0x00 marker.
    assign tx_push      = io_hit && req.wr &&
                          (((io_reg == IO_UART) && (req.data != '0)) || stop_hit);
    assign tx_push_data = stop_hit ? '0 : req.data;
    assign tx_valid     = !tx_empty;
    assign tx_pop       = tx_valid && tx_ready;
    assign io_buffer_full = (tx_count >= TX_CNT_W'(TX_DEPTH - 2));

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = io_hit && !req.wr && (io_reg == IO_UART) && !rx_empty;

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    byte_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // Read-data select for the address presented this cycle.
    always_comb begin
        rd_next = '0;
        if (!io_hit) begin
            rd_next = ram[ram_idx];
        end else begin
            case (io_reg)
                IO_UART: rd_next = rx_empty ? '0 : rx_head;
                IO_CNT:  rd_next = cycle_cnt[{cnt_byte, 3'b000} +: BYTE_W];
                default: rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din      <= '0;
            cycle_cnt    <= '0;
            program_stop <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + CYC_W'(1);
            if (!req.wr) begin
                mem_din <= rd_next;
            end
            if (stop_hit) begin
                program_stop <= 1'b1;
            end
            if (tx_push && tx_full && !tx_pop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, UART TX/RX FIFOs, cycle counter and stop register.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_exp [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h00};

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one bus cycle at a falling edge and return at the next falling edge.
    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in   = 1'b0;
        mem_a    = 32'h0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic drain_tx(output int n, output logic [7:0] first, output logic [7:0] last);
        n     = 0;
        first = 8'h00;
        last  = 8'h00;
        tx_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (tx_valid) begin
                if (n == 0) first = tx_data;
                last = tx_data;
                n++;
            end
            cyc(32'h0, 1'b0, 8'h00);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int         n;
        int         hs;
        logic [7:0] first;
        logic [7:0] last;

        rst_in   = 1'b0;
        mem_a    = 32'h0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk_in);
        check("rst_mem_din", mem_din, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_buf_full", io_buffer_full, 0);
        check("rst_stop", program_stop, 0);
        check("rst_ovf", tx_overflow, 0);
        rst_in = 1'b1;

        // RAM write/read, including the upper half of the RAM window
        cyc(32'h0000_0100, 1'b1, 8'hA5);
        cyc(32'h0000_0100, 1'b0, 8'h00);
        check("ram_rd_after_wr", mem_din, 32'hA5);
        cyc(32'h0001_FFFF, 1'b1, 8'h3C);
        cyc(32'h0001_0020, 1'b1, 8'h5C);
        cyc(32'h0001_FFFF, 1'b0, 8'h00);
        check("ram_rd_top", mem_din, 32'h3C);
        cyc(32'h0001_0020, 1'b0, 8'h00);
        check("ram_rd_bank1", mem_din, 32'h5C);
        cyc(32'h0000_0100, 1'b0, 8'h00);
        check("ram_rd_keep", mem_din, 32'hA5);
        cyc(32'h0003_0010, 1'b0, 8'h00);
        check("io_other_rd", mem_din, 0);
        cyc(32'h0003_0010, 1'b1, 8'h55);
        cyc(32'h0, 1'b0, 8'h00);
        check("io_other_wr_ignored", tx_valid, 0);

        // One real byte then a zero byte: a single handshake
        tx_ready = 1'b1;
        hs = 0;
        cyc(32'h0003_0000, 1'b1, 8'h41);
        check("tx_data_41", tx_data, 32'h41);
        if (tx_valid && tx_ready) hs++;
        cyc(32'h0003_0000, 1'b1, 8'h00);
        if (tx_valid && tx_ready) hs++;
        for (int k = 0; k < 6; k++) begin
            cyc(32'h0, 1'b0, 8'h00);
            if (tx_valid && tx_ready) hs++;
        end
        check("tx_one_handshake", hs, 1);
        tx_ready = 1'b0;

        // Fill TX with the sink stalled: near-full at 14, the 17th byte is lost
        for (int i = 1; i <= 13; i++) cyc(32'h0003_0000, 1'b1, 8'(i));
        check("tx_near_full_13", io_buffer_full, 0);
        cyc(32'h0003_0000, 1'b1, 8'd14);
        check("tx_near_full_14", io_buffer_full, 1);
        cyc(32'h0003_0000, 1'b1, 8'd15);
        cyc(32'h0003_0000, 1'b1, 8'd16);
        check("tx_no_ovf_16", tx_overflow, 0);
        cyc(32'h0003_0000, 1'b1, 8'd17);
        check("tx_ovf_17", tx_overflow, 1);
        cyc(32'h0, 1'b0, 8'h00);
        drain_tx(n, first, last);
        check("tx_drain_count", n, 16);
        check("tx_drain_first", first, 32'h01);
        check("tx_drain_last", last, 32'h10);
        check("tx_drained_empty", tx_valid, 0);
        check("tx_ovf_sticky", tx_overflow, 1);

        // Push into a full TX FIFO while it pops: accepted, no overflow
        do_reset();
        check("rst_clears_ovf", tx_overflow, 0);
        for (int i = 0; i < 16; i++) cyc(32'h0003_0000, 1'b1, 8'(8'h10 + i));
        tx_ready = 1'b1;
        cyc(32'h0003_0000, 1'b1, 8'h77);
        tx_ready = 1'b0;
        check("tx_full_pushpop_ovf", tx_overflow, 0);
        check("tx_full_pushpop_head", tx_data, 32'h11);
        cyc(32'h0, 1'b0, 8'h00);
        drain_tx(n, first, last);
        check("tx_pushpop_count", n, 16);
        check("tx_pushpop_last", last, 32'h77);

        // RX: single byte then empty read
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        cyc(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        check("rx_rd_5a", mem_din, 32'h5A);
        cyc(32'h0003_0000, 1'b0, 8'h00);
        check("rx_rd_empty", mem_din, 0);

        // RX: push and pop in the same cycle, then fill and refuse an extra byte
        rx_valid = 1'b1;
        rx_data = 8'h11; cyc(32'h0, 1'b0, 8'h00);
        rx_data = 8'h22; cyc(32'h0, 1'b0, 8'h00);
        rx_data = 8'h33; cyc(32'h0, 1'b0, 8'h00);
        rx_data = 8'h44; cyc(32'h0003_0000, 1'b0, 8'h00);
        check("rx_pushpop_rd", mem_din, 32'h11);
        check("rx_pushpop_ready", rx_ready, 1);
        rx_data = 8'h55; cyc(32'h0, 1'b0, 8'h00);
        check("rx_full_ready", rx_ready, 0);
        rx_data = 8'h66; cyc(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(32'h0003_0000, 1'b0, 8'h00);
            check($sformatf("rx_seq_%0d", i), mem_din, 32'(rx_exp[i]));
        end
        check("rx_ready_after", rx_ready, 1);

        // Cycle counter: 254 edges after reset release it reads 0xFE
        do_reset();
        repeat (254) cyc(32'h0, 1'b0, 8'h00);
        cyc(32'h0003_0004, 1'b0, 8'h00);
        check("cnt_b0_fe", mem_din, 32'hFE);
        cyc(32'h0003_0005, 1'b0, 8'h00);
        check("cnt_b1_ff", mem_din, 0);
        cyc(32'h0003_0006, 1'b0, 8'h00);
        check("cnt_b2_100", mem_din, 0);
        cyc(32'h0003_0007, 1'b0, 8'h00);
        check("cnt_b3_101", mem_din, 0);
        cyc(32'h0003_0004, 1'b0, 8'h00);
        check("cnt_b0_102", mem_din, 32'h02);
        cyc(32'h0003_0005, 1'b0, 8'h00);
        check("cnt_b1_103", mem_din, 32'h01);

        // Counter wrap from all-ones
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        cyc(32'h0003_0007, 1'b0, 8'h00);
        check("cnt_b3_max", mem_din, 32'hFF);
        release dut.cycle_cnt;
        cyc(32'h0, 1'b0, 8'h00);
        cyc(32'h0003_0007, 1'b0, 8'h00);
        check("cnt_b3_wrapped", mem_din, 0);
        cyc(32'h0003_0006, 1'b0, 8'h00);
        check("cnt_b2_wrapped", mem_din, 0);

        // Stop register, then reset while TX and RX hold data
        tx_ready = 1'b0;
        cyc(32'h0003_0004, 1'b1, 8'h99);
        check("stop_set", program_stop, 1);
        check("stop_tx_valid", tx_valid, 1);
        check("stop_tx_zero", tx_data, 0);
        tx_ready = 1'b1;
        cyc(32'h0, 1'b0, 8'h00);
        tx_ready = 1'b0;
        check("stop_single_byte", tx_valid, 0);
        check("stop_sticky", program_stop, 1);
        cyc(32'h0003_0005, 1'b1, 8'h55);
        check("cnt_wr_ignored", tx_valid, 0);
        cyc(32'h0003_0004, 1'b1, 8'h00);
        check("stop_again_tx", tx_valid, 1);
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        repeat (4) cyc(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        check("rx_filled", rx_ready, 0);
        rst_in = 1'b0;
        #1;
        check("arst_stop", program_stop, 0);
        check("arst_tx_valid", tx_valid, 0);
        check("arst_rx_ready", rx_ready, 1);
        check("arst_buf_full", io_buffer_full, 0);
        check("arst_mem_din", mem_din, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        check("rx_discarded", mem_din, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
